matmul_seq_ctrl: RTL
====================

Name: matmul_seq_ctrl

Overview:
Sequencer for the combinational 4x4-max matrix multiplier. Accepts a job command with dimensions, then streams operand A and operand B in one 16-bit element per beat, row-major. Packs both operands into the multiplier's 256-bit flat buses, launches the multiply, waits a fixed settle time and captures the result. Streams the product back out row-major with a valid/ready handshake. Sits between the host-side loader and the multiplier instance.

Parameters:
DATA_W, 16, element width; must match the multiplier element width.
MAX_N, 4, largest supported square dimension; flat bus width = MAX_N*MAX_N*DATA_W = 256.
MULT_WAIT, 2, cycles held in WAIT after launch before res_mat is captured; must be >= 1.

Ports:
CLK  in  1  system clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
cmd_valid  in  1  job command present.
cmd_ready  out  1  high only in IDLE.
cmd_r1, cmd_c1, cmd_r2, cmd_c2  in  4 each  operand dimensions.
in_valid  in  1  operand element valid.
in_ready  out  1  high in LOAD_A/LOAD_B.
in_data  in  DATA_W  operand element.
out_valid  out  1  result element valid.
out_ready  in  1  downstream accepts result element.
out_data  out  DATA_W  result element.
out_last  out  1  marks the final result element of a job.
err  out  1  one-cycle pulse on a rejected command.
busy  out  1  high in any state other than IDLE.
mm_flat_1, mm_flat_2  out  256  to multiplier flat_matrix_1/2.
mm_r1, mm_c1, mm_r2, mm_c2  out  4 each  to multiplier R1/C1/R2/C2.
mm_readybit  out  1  to multiplier readybit.
mm_res  in  256  from multiplier res_mat.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, except cmd_ready=1. Operand registers, result register, counters and mm_* outputs are cleared. Reset asserted mid-job aborts the job; no output beat is produced.
- States: IDLE, LOAD_A, LOAD_B, LAUNCH, WAIT, DRAIN.
- IDLE: when cmd_valid and cmd_ready are both high, dimensions are checked.
  - Accept only if r1==c1==r2==c2 and n is in {2,3,4}.
  - Accept: latch n, clear flat registers to 0, element counter k=0, go to LOAD_A.
  - Reject: err=1 for one cycle, stay in IDLE.
- LOAD_A: each in_valid & in_ready beat writes element k to mm_flat_1[255-16k -: 16] (MSB-aligned), then k++. When k==n*n-1 is accepted, go to LOAD_B with k=0.
- LOAD_B: same packing into mm_flat_2. On the last beat, go to LAUNCH.
- LAUNCH: mm_r1/c1/r2/c2 are already driven with n. Toggle mm_readybit once, because the multiplier evaluates on any readybit edge. Go to WAIT with wait counter = MULT_WAIT.
- WAIT: decrement the counter each cycle. At 0, capture mm_res into the result register, set k=0, go to DRAIN.
- DRAIN: out_data = result element k, taken LSB-aligned from bits [(n*n-k)*16-1 -: 16].
  - out_valid=1, and out_last=1 when k==n*n-1.
  - A beat completes on out_valid & out_ready, then k++.
  - While out_ready=0, out_data, out_valid and out_last hold stable.
  - After the last beat, go to IDLE; busy drops the next cycle.
- Arithmetic: products and sums are formed by the multiplier and truncated to 16 bits (mod 2^16). The controller performs no arithmetic beyond counters.
- cmd_valid outside IDLE is ignored (cmd_ready=0). in_valid outside the LOAD states is ignored.
- mm_flat buses hold their values from LAUNCH through DRAIN.

Decomposition:
- Shared package matmul_pkg:
  - state enum (IDLE..DRAIN);
  - DATA_W and MAX_N constants;
  - the function elem_msb_off(k) for operand slicing;
  - the function res_lsb_off(n,k) for result slicing.
- One natural sub-module: matmul_operand_packer. It holds one 256-bit register with clear and indexed element write. It is instantiated twice (A and B). FSM and counters stay in the top.

Test Plan:
- 2x2: A=[1 2;3 4], B=[5 6;7 8] -> outputs 19, 22, 43, 50; out_last only on 50; busy low the cycle after.
- 3x3: A=identity, B=1..9 -> outputs 1..9 in order; mm_flat_1 unused low 112 bits stay 0.
- 4x4: all elements 2 in both operands -> 16 outputs each 16; mm_readybit toggles exactly once per job.
- Bad command: r1=c1=r2=c2=5, then r1=2,c1=2,r2=3,c2=3 -> err pulse each, state stays IDLE, in_ready=0.
- Backpressure and overflow: 2x2 with A=B=[300 0;0 0], out_ready low 3 cycles on the first beat -> out_data holds 24464 (90000 mod 65536), then 0, 0, 0.
- Reset mid-LOAD_B after 2 beats -> all outputs 0, cmd_ready=1; a fresh 2x2 job completes correctly.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and slicing helpers for the matrix multiplier sequencer.
package matmul_pkg;

    localparam int DATA_W = 16;
    localparam int MAX_N  = 4;
    localparam int FLAT_W = MAX_N * MAX_N * DATA_W;
    localparam int IDX_W  = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD_A = 3'd1;
    localparam state_t ST_LOAD_B = 3'd2;
    localparam state_t ST_LAUNCH = 3'd3;
    localparam state_t ST_WAIT   = 3'd4;
    localparam state_t ST_DRAIN  = 3'd5;

    // Top bit of operand element k; operands are packed MSB-first into the flat bus.
    function automatic logic [7:0] elem_msb_off(input logic [IDX_W-1:0] k);
        int off;
        off = FLAT_W - 1 - DATA_W * int'(k);
        return off[7:0];
    endfunction

    // Bottom bit of result element k for an n x n product; the multiplier packs results at the low end.
    function automatic logic [7:0] res_lsb_off(input logic [2:0] n, input logic [IDX_W-1:0] k);
        int off;
        off = (int'(n) * int'(n) - int'(k) - 1) * DATA_W;
        return off[7:0];
    endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Host-side command, operand and result handshakes of the matrix multiplier sequencer.
interface matmul_seq_ctrl_if;
    import matmul_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_r1;
    logic [3:0]        cmd_c1;
    logic [3:0]        cmd_r2;
    logic [3:0]        cmd_c2;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              err;
    logic              busy;

    modport master (
        output cmd_valid, cmd_r1, cmd_c1, cmd_r2, cmd_c2, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data, out_last, err, busy
    );

    modport slave (
        input  cmd_valid, cmd_r1, cmd_c1, cmd_r2, cmd_c2, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data, out_last, err, busy
    );

endinterface

// File: rtl/matmul_operand_packer.sv
// One operand matrix held as the multiplier's flat bus, with job-start clear and per-element write.
module matmul_operand_packer
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [FLAT_W-1:0] flat
);

    logic [FLAT_W-1:0] flat_r;

    // Clear at job start, otherwise drop each accepted element into its MSB-aligned slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flat_r <= {FLAT_W{1'b0}};
        end else if (clr) begin
            flat_r <= {FLAT_W{1'b0}};
        end else if (wr_en) begin
            flat_r[elem_msb_off(wr_idx) -: DATA_W] <= wr_data;
        end else begin
            flat_r <= flat_r;
        end
    end

    assign flat = flat_r;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer: takes a square job command, loads A and B, pulses the multiplier, streams the product out.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int MULT_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    matmul_seq_ctrl_if.slave  host,
    output logic [FLAT_W-1:0] mm_flat_1,
    output logic [FLAT_W-1:0] mm_flat_2,
    output logic [3:0]        mm_r1,
    output logic [3:0]        mm_c1,
    output logic [3:0]        mm_r2,
    output logic [3:0]        mm_c2,
    output logic              mm_readybit,
    input  logic [FLAT_W-1:0] mm_res
);

    localparam int WAIT_W = (MULT_WAIT < 2) ? 1 : $clog2(MULT_WAIT + 1);

    state_t             state_r, state_s;
    logic [2:0]         n_r, n_s;
    logic [IDX_W-1:0]   k_r, k_s;
    logic [WAIT_W-1:0]  wait_r, wait_s;
    logic [FLAT_W-1:0]  res_r;
    logic               mm_readybit_r;

    logic               cmd_ready_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               out_last_r;
    logic [DATA_W-1:0]  out_data_r, out_data_s;
    logic               err_r;
    logic               busy_r;

    logic               clr_s, wr_a_s, wr_b_s, cap_s, err_s, tog_s;
    logic               cmd_fire_s, in_fire_s, out_fire_s, dims_ok_s;
    logic [4:0]         nn_s, last_idx_s;
    logic               k_last_s, out_last_s;

    assign cmd_fire_s = host.cmd_valid && cmd_ready_r;
    assign in_fire_s  = host.in_valid && in_ready_r;
    assign out_fire_s = out_valid_r && host.out_ready;
    assign dims_ok_s  = (host.cmd_r1 == host.cmd_c1) && (host.cmd_c1 == host.cmd_r2) &&
                        (host.cmd_r2 == host.cmd_c2) &&
                        (host.cmd_r1 >= 4'd2) && (host.cmd_r1 <= 4'd4);

    assign nn_s       = {2'b00, n_r} * {2'b00, n_r};
    assign last_idx_s = nn_s - 5'd1;
    assign k_last_s   = ({1'b0, k_r} == last_idx_s);
    assign out_last_s = (state_s == ST_DRAIN) && ({1'b0, k_s} == last_idx_s);

    // Next-state, counter and result-element selection for the job sequence.
    always_comb begin
        state_s    = state_r;
        n_s        = n_r;
        k_s        = k_r;
        wait_s     = wait_r;
        clr_s      = 1'b0;
        wr_a_s     = 1'b0;
        wr_b_s     = 1'b0;
        cap_s      = 1'b0;
        err_s      = 1'b0;
        tog_s      = 1'b0;
        out_data_s = out_data_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_fire_s && dims_ok_s) begin
                    n_s     = host.cmd_r1[2:0];
                    clr_s   = 1'b1;
                    k_s     = {IDX_W{1'b0}};
                    state_s = ST_LOAD_A;
                end else if (cmd_fire_s) begin
                    err_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD_A: begin
                if (in_fire_s) begin
                    wr_a_s = 1'b1;
                    if (k_last_s) begin
                        k_s     = {IDX_W{1'b0}};
                        state_s = ST_LOAD_B;
                    end else begin
                        k_s = k_r + 4'd1;
                    end
                end else begin
                    k_s = k_r;
                end
            end
            ST_LOAD_B: begin
                if (in_fire_s) begin
                    wr_b_s = 1'b1;
                    if (k_last_s) begin
                        k_s     = {IDX_W{1'b0}};
                        state_s = ST_LAUNCH;
                    end else begin
                        k_s = k_r + 4'd1;
                    end
                end else begin
                    k_s = k_r;
                end
            end
            ST_LAUNCH: begin
                // Any readybit edge makes the multiplier evaluate, so one flip per job.
                tog_s   = 1'b1;
                wait_s  = WAIT_W'(MULT_WAIT);
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_r == {WAIT_W{1'b0}}) begin
                    cap_s      = 1'b1;
                    k_s        = {IDX_W{1'b0}};
                    out_data_s = mm_res[res_lsb_off(n_r, 4'd0) +: DATA_W];
                    state_s    = ST_DRAIN;
                end else begin
                    wait_s = wait_r - WAIT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (out_fire_s && k_last_s) begin
                    k_s        = {IDX_W{1'b0}};
                    out_data_s = {DATA_W{1'b0}};
                    state_s    = ST_IDLE;
                end else if (out_fire_s) begin
                    k_s        = k_r + 4'd1;
                    out_data_s = res_r[res_lsb_off(n_r, k_r + 4'd1) +: DATA_W];
                end else begin
                    out_data_s = out_data_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, captured result and all registered host/multiplier outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            n_r           <= 3'd0;
            k_r           <= {IDX_W{1'b0}};
            wait_r        <= {WAIT_W{1'b0}};
            res_r         <= {FLAT_W{1'b0}};
            mm_readybit_r <= 1'b0;
            cmd_ready_r   <= 1'b1;
            in_ready_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            out_data_r    <= {DATA_W{1'b0}};
            err_r         <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            n_r           <= n_s;
            k_r           <= k_s;
            wait_r        <= wait_s;
            res_r         <= cap_s ? mm_res : res_r;
            mm_readybit_r <= mm_readybit_r ^ tog_s;
            cmd_ready_r   <= (state_s == ST_IDLE);
            in_ready_r    <= (state_s == ST_LOAD_A) || (state_s == ST_LOAD_B);
            out_valid_r   <= (state_s == ST_DRAIN);
            out_last_r    <= out_last_s;
            out_data_r    <= out_data_s;
            err_r         <= err_s;
            busy_r        <= (state_s != ST_IDLE);
        end
    end

    matmul_operand_packer u_pack_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_s),
        .wr_en   (wr_a_s),
        .wr_idx  (k_r),
        .wr_data (host.in_data),
        .flat    (mm_flat_1)
    );

    matmul_operand_packer u_pack_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_s),
        .wr_en   (wr_b_s),
        .wr_idx  (k_r),
        .wr_data (host.in_data),
        .flat    (mm_flat_2)
    );

    assign mm_r1       = {1'b0, n_r};
    assign mm_c1       = {1'b0, n_r};
    assign mm_r2       = {1'b0, n_r};
    assign mm_c2       = {1'b0, n_r};
    assign mm_readybit = mm_readybit_r;

    assign host.cmd_ready = cmd_ready_r;
    assign host.in_ready  = in_ready_r;
    assign host.out_valid = out_valid_r;
    assign host.out_last  = out_last_r;
    assign host.out_data  = out_data_r;
    assign host.err       = err_r;
    assign host.busy      = busy_r;

endmodule
